// File: rtl/wb_pkg.sv
// Shared encodings and the sub-word load extraction used by the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_e;

  // Works on a 64-bit container; a 32-bit datapath passes wide=0 and truncates the result.
  function automatic logic [63:0] wb_load_ext(
    input logic [63:0] data,
    input logic [1:0]  size,
    input logic [2:0]  offset,
    input logic        sgn,
    input logic        wide
  );
    logic [1:0]  eff;
    logic [2:0]  lane;
    logic [63:0] sh;
    logic [63:0] res;
    eff = size;
    if (!wide && size == SZ_DWORD) eff = SZ_WORD;
    case (eff)
      SZ_BYTE: lane = offset;
      SZ_HALF: lane = {offset[2:1], 1'b0};
      SZ_WORD: lane = {offset[2], 2'b00};
      default: lane = 3'd0;
    endcase
    sh = data >> {lane, 3'b000};
    case (eff)
      SZ_BYTE: res = {{56{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{48{sgn & sh[15]}}, sh[15:0]};
      SZ_WORD: res = {{32{sgn & sh[31]}}, sh[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// Small queue for multi-cycle unit results, with per-entry address match for decode hazard queries.
module wb_aux_fifo #(
  parameter int ADDR_SIZE  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [ADDR_SIZE-1:0]     i_push_addr,
  input  logic [DATA_WIDTH-1:0]    i_push_data,
  input  logic                     i_pop,
  output logic [ADDR_SIZE-1:0]     o_head_addr,
  output logic [DATA_WIDTH-1:0]    o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic [ADDR_SIZE-1:0]     i_query_a,
  input  logic [ADDR_SIZE-1:0]     i_query_b,
  output logic                     o_match_a,
  output logic                     o_match_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_SIZE-1:0]  r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + PW'(1);
      end
      // Push is only offered below full, so the write slot never aliases the popped slot.
      if (i_push) begin
        r_vld[r_wr]  <= 1'b1;
        r_addr[r_wr] <= i_push_addr;
        r_data[r_wr] <= i_push_data;
        r_wr         <= r_wr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match_a = 1'b0;
    o_match_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_addr[i] == i_query_a) o_match_a = 1'b1;
      if (r_vld[i] && r_addr[i] == i_query_b) o_match_b = 1'b1;
    end
  end

  assign o_head_addr = r_addr[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_count     = r_count;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: result select, load alignment/extension, and arbitration of the
// pipeline against queued aux results onto one registered register-file write port.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int ADDR_SIZE    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_wb,
  output logic                              wb_ready,
  input  logic                              reg_d_we_wb,
  input  logic [ADDR_SIZE-1:0]              reg_d_addr_wb,
  input  logic [1:0]                        data_sel_wb,
  input  logic [1:0]                        mem_size_wb,
  input  logic                              mem_signed_wb,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   mem_offset_wb,
  input  logic [DATA_WIDTH-1:0]             alu_data_wb,
  input  logic [DATA_WIDTH-1:0]             mem_data_wb,
  input  logic [DATA_WIDTH-1:0]             link_data_wb,
  input  logic                              aux_valid,
  output logic                              aux_ready,
  input  logic [ADDR_SIZE-1:0]              aux_addr,
  input  logic [DATA_WIDTH-1:0]             aux_data,
  input  logic [ADDR_SIZE-1:0]              query_addr_a,
  input  logic [ADDR_SIZE-1:0]              query_addr_b,
  output logic                              pending_a,
  output logic                              pending_b,
  output logic                              reg_d_we,
  output logic [ADDR_SIZE-1:0]              reg_d_addr,
  output logic [DATA_WIDTH-1:0]             reg_d_data
);

  localparam int CW = $clog2(AUX_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]         w_count;
  logic [ADDR_SIZE-1:0]  w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_match_a;
  logic                  w_match_b;
  logic                  w_fifo_ne;
  logic                  w_starve;
  logic                  w_pipe_eff;
  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_mem_ext;
  logic [DATA_WIDTH-1:0] w_pipe_data;

  logic [SW-1:0]         r_starve_cnt;
  logic                  r_we;
  logic [ADDR_SIZE-1:0]  r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  wb_aux_fifo #(
    .ADDR_SIZE  (ADDR_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (AUX_DEPTH)
  ) u_aux_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_addr (aux_addr),
    .i_push_data (aux_data),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .i_query_a   (query_addr_a),
    .i_query_b   (query_addr_b),
    .o_match_a   (w_match_a),
    .o_match_b   (w_match_b)
  );

  assign w_fifo_ne = (w_count != '0);
  assign w_starve  = (r_starve_cnt >= SW'(STARVE_LIMIT));

  assign wb_ready  = ~rst_n | ~(w_starve & w_fifo_ne);
  assign aux_ready = rst_n & (w_count < CW'(AUX_DEPTH));

  assign w_pipe_eff = valid_wb & wb_ready & reg_d_we_wb & (reg_d_addr_wb != '0);
  // Head wins when starving; otherwise it fills any cycle the pipeline leaves idle.
  assign w_pop      = rst_n & w_fifo_ne & (w_starve | ~w_pipe_eff);
  // Writes to r0 are acknowledged but never occupy a slot.
  assign w_push     = aux_valid & aux_ready & (aux_addr != '0);

  assign w_mem_ext = DATA_WIDTH'(wb_load_ext(64'(mem_data_wb), mem_size_wb,
                                             3'(mem_offset_wb), mem_signed_wb,
                                             DATA_WIDTH == 64));

  always_comb begin
    w_pipe_data = alu_data_wb;
    case (data_sel_wb)
      WB_SEL_MEM:  w_pipe_data = w_mem_ext;
      WB_SEL_LINK: w_pipe_data = link_data_wb;
      default:     w_pipe_data = alu_data_wb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      r_we   <= 1'b1;
      r_addr <= w_head_addr;
      r_data <= w_head_data;
    end else if (w_pipe_eff) begin
      r_we   <= 1'b1;
      r_addr <= reg_d_addr_wb;
      r_data <= w_pipe_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_pop || !w_fifo_ne) begin
      r_starve_cnt <= '0;
    end else if (!w_starve) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  assign pending_a  = (query_addr_a != '0) & w_match_a;
  assign pending_b  = (query_addr_b != '0) & w_match_b;

  assign reg_d_we   = r_we;
  assign reg_d_addr = r_addr;
  assign reg_d_data = r_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_writeback_unit;

  localparam int AS    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int OW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_wb, wb_ready, reg_d_we_wb, mem_signed_wb;
  logic [AS-1:0] reg_d_addr_wb;
  logic [1:0]    data_sel_wb, mem_size_wb;
  logic [OW-1:0] mem_offset_wb;
  logic [DW-1:0] alu_data_wb, mem_data_wb, link_data_wb;
  logic          aux_valid, aux_ready;
  logic [AS-1:0] aux_addr;
  logic [DW-1:0] aux_data;
  logic [AS-1:0] query_addr_a, query_addr_b;
  logic          pending_a, pending_b;
  logic          reg_d_we;
  logic [AS-1:0] reg_d_addr;
  logic [DW-1:0] reg_d_data;

  always #5 clk = ~clk;

  writeback_unit #(
    .ADDR_SIZE(AS), .DATA_WIDTH(DW), .AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_wb(valid_wb), .wb_ready(wb_ready),
    .reg_d_we_wb(reg_d_we_wb), .reg_d_addr_wb(reg_d_addr_wb), .data_sel_wb(data_sel_wb),
    .mem_size_wb(mem_size_wb), .mem_signed_wb(mem_signed_wb), .mem_offset_wb(mem_offset_wb),
    .alu_data_wb(alu_data_wb), .mem_data_wb(mem_data_wb), .link_data_wb(link_data_wb),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .query_addr_a(query_addr_a), .query_addr_b(query_addr_b),
    .pending_a(pending_a), .pending_b(pending_b),
    .reg_d_we(reg_d_we), .reg_d_addr(reg_d_addr), .reg_d_data(reg_d_data)
  );

  typedef struct {
    logic [AS-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int      n_tests = 0;
  int      n_fail  = 0;
  ent_t    mq[$];
  int      m_cnt   = 0;
  bit      e_we    = 0;
  bit      e_all   = 1;
  logic [AS-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  bit      last_wbr = 1;
  bit      last_axr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Little-endian sub-word pick from byte counts, independent of any lane encoding.
  function automatic logic [DW-1:0] m_load(input logic [DW-1:0] mem, input int size,
                                           input int off, input bit sgn);
    logic [63:0] v, mask;
    int nb, lane, maxlog;
    maxlog = $clog2(DW / 8);
    nb     = 1 << ((size > maxlog) ? maxlog : size);
    lane   = off & ~(nb - 1);
    v      = 64'(mem) >> (lane * 8);
    mask   = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
    v      = v & mask;
    if (sgn && v[nb*8-1]) v = v | ~mask;
    return v[DW-1:0];
  endfunction

  function automatic bit m_pending(input logic [AS-1:0] qa);
    if (qa == '0) return 0;
    foreach (mq[i]) if (mq[i].a == qa) return 1;
    return 0;
  endfunction

  // Check combinational outputs, advance the model over the coming edge, then check the port.
  task automatic step();
    bit   m_wbr, m_axr, eff, ne;
    ent_t ent;
    #1;
    m_wbr = !rst_n || !(m_cnt >= LIM && mq.size() > 0);
    m_axr = rst_n && (mq.size() < DEPTH);
    chk("wb_ready", 64'(wb_ready), 64'(m_wbr));
    chk("aux_ready", 64'(aux_ready), 64'(m_axr));
    chk("pending_a", 64'(pending_a), 64'(m_pending(query_addr_a)));
    chk("pending_b", 64'(pending_b), 64'(m_pending(query_addr_b)));
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; e_we = 0; e_all = 1; e_addr = '0; e_data = '0;
    end else begin
      e_all = 0;
      eff   = valid_wb && m_wbr && reg_d_we_wb && reg_d_addr_wb != '0;
      ne    = mq.size() > 0;
      if (ne && (m_cnt >= LIM || !eff)) begin
        ent = mq.pop_front();
        e_we = 1; e_addr = ent.a; e_data = ent.d;
        m_cnt = 0;
      end else begin
        if (eff) begin
          e_we = 1; e_addr = reg_d_addr_wb;
          case (data_sel_wb)
            2'd1:    e_data = m_load(mem_data_wb, int'(mem_size_wb), int'(mem_offset_wb), mem_signed_wb);
            2'd2:    e_data = link_data_wb;
            default: e_data = alu_data_wb;
          endcase
        end else begin
          e_we = 0;
        end
        m_cnt = ne ? m_cnt + 1 : 0;
      end
      if (aux_valid && m_axr && aux_addr != '0) begin
        ent.a = aux_addr; ent.d = aux_data;
        mq.push_back(ent);
      end
    end
    last_wbr = m_wbr;
    last_axr = m_axr;
    @(posedge clk);
    @(negedge clk);
    chk("reg_d_we", 64'(reg_d_we), 64'(e_we));
    if (e_we || e_all) begin
      chk("reg_d_addr", 64'(reg_d_addr), 64'(e_addr));
      chk("reg_d_data", 64'(reg_d_data), 64'(e_data));
    end
  endtask

  task automatic pipe(input bit v, input bit we, input logic [AS-1:0] a, input logic [1:0] sel,
                      input logic [DW-1:0] alu);
    valid_wb = v; reg_d_we_wb = we; reg_d_addr_wb = a; data_sel_wb = sel; alu_data_wb = alu;
  endtask

  task automatic load(input logic [1:0] sz, input logic [OW-1:0] off, input bit sgn);
    valid_wb = 1; reg_d_we_wb = 1; reg_d_addr_wb = 5'd6; data_sel_wb = 2'd1;
    mem_data_wb = 32'h80FF_7F01; mem_size_wb = sz; mem_offset_wb = off; mem_signed_wb = sgn;
  endtask

  task automatic aux(input bit v, input logic [AS-1:0] a, input logic [DW-1:0] d);
    aux_valid = v; aux_addr = a; aux_data = d;
  endtask

  initial begin
    rst_n = 0;
    pipe(0, 0, '0, 2'd0, '0);
    mem_data_wb = '0; link_data_wb = '0; mem_size_wb = 0; mem_offset_wb = 0; mem_signed_wb = 0;
    aux(0, '0, '0);
    query_addr_a = '0; query_addr_b = '0;
    @(negedge clk);
    step(); step();
    chk("rst_we", 64'(reg_d_we), 64'd0);
    chk("rst_addr", 64'(reg_d_addr), 64'd0);
    chk("rst_data", 64'(reg_d_data), 64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    chk("rst_aux_ready", 64'(aux_ready), 64'd0);
    rst_n = 1;

    pipe(1, 1, 5'd5, 2'd0, 32'h1234_5678); step();
    chk("alu_we", 64'(reg_d_we), 64'd1);
    chk("alu_addr", 64'(reg_d_addr), 64'd5);
    chk("alu_data", 64'(reg_d_data), 64'h1234_5678);
    link_data_wb = 32'h0040_0008; data_sel_wb = 2'd2; step();
    chk("link_data", 64'(reg_d_data), 64'h0040_0008);

    load(2'd0, 2'd3, 1); step(); chk("ld_b3s", 64'(reg_d_data), 64'hFFFF_FF80);
    load(2'd1, 2'd2, 0); step(); chk("ld_h2u", 64'(reg_d_data), 64'h0000_80FF);
    load(2'd0, 2'd1, 1); step(); chk("ld_b1s", 64'(reg_d_data), 64'h0000_007F);
    load(2'd1, 2'd3, 0); step(); chk("ld_h3u", 64'(reg_d_data), 64'h0000_80FF);

    pipe(1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF); step();
    chk("r0_pipe_we", 64'(reg_d_we), 64'd0);

    pipe(0, 0, '0, 2'd0, '0);
    aux(1, 5'd0, 32'h0BAD_0BAD); step();
    chk("r0_aux_ready", 64'(aux_ready), 64'd1);
    chk("r0_pending", 64'(pending_a), 64'd0);
    aux(0, '0, '0); step();
    chk("r0_aux_nowrite", 64'(reg_d_we), 64'd0);

    // Fill and drain with an idle pipeline: entries leave as fast as they arrive.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) aux(1, AS'(7 + i), DW'(32'hA + i)); else aux(0, '0, '0);
      chk("fill_aux_ready", 64'(aux_ready), 64'd1);
      step();
      if (i >= 1) begin
        chk("drain_addr", 64'(reg_d_addr), 64'(6 + i));
        chk("drain_data", 64'(reg_d_data), 64'(32'hA + i - 1));
      end
    end
    step();

    // Pipeline writing every cycle blocks pops, so the queue fills.
    query_addr_a = 5'd7;
    for (int i = 0; i < 4; i++) begin
      pipe(1, 1, 5'd3, 2'd0, DW'($urandom));
      aux(1, AS'(7 + i), DW'(32'hB0 + i));
      step();
    end
    aux(0, '0, '0);
    #1;
    chk("full_aux_ready", 64'(aux_ready), 64'd0);
    chk("full_pending_a", 64'(pending_a), 64'd1);
    pipe(0, 0, '0, 2'd0, '0);
    for (int i = 0; i < 6; i++) step();

    // Starvation: one entry waits behind continuous pipeline writes.
    query_addr_a = 5'd12;
    for (int k = 0; k <= 8; k++) begin
      pipe(1, 1, 5'd4, 2'd0, DW'(32'h1000 + k));
      if (k == 0) aux(1, 5'd12, 32'h5A5A); else aux(0, '0, '0);
      step();
    end
    chk("starve_wb_ready", 64'(wb_ready), 64'd0);
    step();
    chk("starve_aux_addr", 64'(reg_d_addr), 64'd12);
    chk("starve_aux_data", 64'(reg_d_data), 64'h5A5A);
    chk("starve_release", 64'(wb_ready), 64'd1);
    step();
    chk("held_addr", 64'(reg_d_addr), 64'd4);
    chk("held_data", 64'(reg_d_data), 64'h1008);
    pipe(0, 0, '0, 2'd0, '0);
    step();

    // Reset with three entries queued.
    query_addr_a = 5'd20;
    for (int i = 0; i < 3; i++) begin
      pipe(1, 1, 5'd2, 2'd0, DW'(i));
      aux(1, AS'(20 + i), DW'(32'hC0 + i));
      step();
    end
    chk("preq_pending_a", 64'(pending_a), 64'd1);
    pipe(0, 0, '0, 2'd0, '0); aux(0, '0, '0);
    rst_n = 0; step();
    chk("midrst_we", 64'(reg_d_we), 64'd0);
    chk("midrst_pending", 64'(pending_a), 64'd0);
    rst_n = 1; step();
    chk("postrst_we", 64'(reg_d_we), 64'd0);
    chk("postrst_aux_ready", 64'(aux_ready), 64'd1);
    step();
    chk("postrst_stale", 64'(reg_d_we), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      if (last_wbr) begin
        valid_wb      = ($urandom_range(0, 3) != 0);
        reg_d_we_wb   = ($urandom_range(0, 4) != 0);
        reg_d_addr_wb = AS'($urandom_range(0, 7));
        data_sel_wb   = 2'($urandom_range(0, 3));
        mem_size_wb   = 2'($urandom_range(0, 3));
        mem_offset_wb = OW'($urandom_range(0, 3));
        mem_signed_wb = 1'($urandom_range(0, 1));
        alu_data_wb   = DW'($urandom);
        mem_data_wb   = DW'($urandom);
        link_data_wb  = DW'($urandom);
      end
      if (!(aux_valid && !last_axr)) begin
        aux_valid = ($urandom_range(0, 2) == 0);
        aux_addr  = AS'($urandom_range(0, 7));
        aux_data  = DW'($urandom);
      end
      query_addr_a = AS'($urandom_range(0, 7));
      query_addr_b = AS'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
